// File: rtl/ram_ctrl.sv
// Byte-wide request/response front end for the asynchronous `ram` block:
// each accepted request becomes a setup / strobe / hold sequence on rdN/wrN.
module ram_ctrl #(
  parameter int SIZE        = 1024,
  parameter int AW          = $clog2(SIZE),
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_wdata,
  output logic          rsp_valid,
  output logic [7:0]    rsp_rdata,
  output logic          wr_done,
  output logic          rsp_err,
  output logic          rdN,
  output logic          wrN,
  output logic [AW-1:0] addr,
  inout  tri   [7:0]    data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam logic [31:0] SIZE_U = SIZE;
  localparam logic [3:0]  STROBE_LAST = 4'(WAIT_STATES - 1);

  logic [2:0] state_reg;
  logic       write_reg;
  logic       data_oe_reg;
  logic [7:0] wdata_reg;
  logic [3:0] cnt_reg;
  logic       in_range;

  // SIZE need not be a power of two, so the top of the address space can be invalid.
  assign in_range  = {{(32-AW){1'b0}}, req_addr} < SIZE_U;
  assign req_ready = (state_reg == IDLE);
  assign data      = data_oe_reg ? wdata_reg : 8'bz;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg   <= IDLE;
      write_reg   <= 1'b0;
      data_oe_reg <= 1'b0;
      wdata_reg   <= 8'h00;
      cnt_reg     <= 4'd0;
      rdN         <= 1'b1;
      wrN         <= 1'b1;
      addr        <= '0;
      rsp_valid   <= 1'b0;
      wr_done     <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg <= req_write;
            wdata_reg <= req_wdata;
            if (in_range) begin
              state_reg   <= SETUP;
              addr        <= req_addr;
              data_oe_reg <= req_write;
            end else begin
              state_reg <= ERR;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_reg <= STROBE;
          cnt_reg   <= STROBE_LAST;
          rdN       <= write_reg;
          wrN       <= ~write_reg;
        end
        STROBE: begin
          // Read data is captured while rdN is still low on this edge.
          if (cnt_reg == 4'd0) begin
            state_reg <= HOLD;
            rdN       <= 1'b1;
            wrN       <= 1'b1;
            rsp_valid <= ~write_reg;
            wr_done   <= write_reg;
            if (!write_reg) begin
              rsp_rdata <= data;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        HOLD: begin
          state_reg   <= IDLE;
          rsp_valid   <= 1'b0;
          wr_done     <= 1'b0;
          data_oe_reg <= 1'b0;
        end
        ERR: begin
          state_reg <= IDLE;
          rsp_err   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: three instances (SIZE/W = 1024/2, 1000/1, 1024/15),
// each attached to a simple byte RAM model, checked cycle by cycle.
module tb_ram_ctrl;

  logic clk;
  logic rst_n;

  logic       rv    [3];
  logic       rw    [3];
  logic [9:0] ra    [3];
  logic [7:0] rd    [3];
  logic       rdy   [3];
  logic       rspv  [3];
  logic       wdn   [3];
  logic       rerr  [3];
  logic       rdn   [3];
  logic       wrn   [3];
  logic [7:0] rdata [3];
  logic [9:0] ao    [3];
  logic [7:0] dsample [3];

  logic [7:0] refm [3][1024];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    tri [7:0] dbus;
    logic [7:0] mem [1024];

    ram_ctrl #(
      .SIZE        (gi == 1 ? 1000 : 1024),
      .WAIT_STATES (gi == 0 ? 2 : (gi == 1 ? 1 : 15))
    ) u_dut (
      .clk       (clk),
      .rstN      (rst_n),
      .req_valid (rv[gi]),
      .req_ready (rdy[gi]),
      .req_write (rw[gi]),
      .req_addr  (ra[gi]),
      .req_wdata (rd[gi]),
      .rsp_valid (rspv[gi]),
      .rsp_rdata (rdata[gi]),
      .wr_done   (wdn[gi]),
      .rsp_err   (rerr[gi]),
      .rdN       (rdn[gi]),
      .wrN       (wrn[gi]),
      .addr      (ao[gi]),
      .data      (dbus)
    );

    // RAM model: drives the bus while rdN is low, stores while wrN is low.
    assign dbus = !rdn[gi] ? mem[ao[gi]] : 8'bz;
    assign dsample[gi] = dbus;

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
      if (!wrn[gi]) mem[ao[gi]] <= dbus;
    end
  end

  typedef struct {
    int         k;
    bit         wr;
    logic [9:0] a;
    logic [7:0] d;
    bit         err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic int wst(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic int size_of(input int k);
    return (k == 1) ? 1000 : 1024;
  endfunction

  // {req_ready, rdN, wrN, rsp_valid, wr_done, rsp_err}
  function automatic logic [5:0] ctl(input int k);
    return {rdy[k], rdn[k], wrn[k], rspv[k], wdn[k], rerr[k]};
  endfunction

  // Expected control outputs in cycle n after the handshake edge E0.
  function automatic logic [5:0] exp_ctl(input int w, input bit wr, input bit err, input int n);
    if (err) return (n == 0) ? 6'b011001 : 6'b111000;
    if (n == 0) return 6'b011000;
    if (n <= w) return {1'b0, wr, ~wr, 3'b000};
    if (n == w + 1) return {3'b011, ~wr, wr, 1'b0};
    return 6'b111000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Starts just after the handshake edge; ends at the negedge of cycle W+2 (IDLE).
  task automatic watch(input int k, input bit wr, input logic [9:0] a, input logic [7:0] d,
                       input bit err, input logic [7:0] exp_rd);
    int w;
    int last;
    w = wst(k);
    last = err ? 1 : w + 2;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      chk($sformatf("ctl k%0d n%0d", k, n), 32'(ctl(k)), 32'(exp_ctl(w, wr, err, n)));
      if (!err && n <= w + 1) chk($sformatf("addr k%0d n%0d", k, n), 32'(ao[k]), 32'(a));
      if (!err && wr && n <= w + 1) chk($sformatf("bus k%0d n%0d", k, n), 32'(dsample[k]), 32'(d));
      if (!err && !wr && n >= w + 1) chk($sformatf("rdata k%0d n%0d", k, n), 32'(rdata[k]), 32'(exp_rd));
    end
  endtask

  // Called at a negedge in IDLE; handshake on the following posedge.
  task automatic txn(input int k, input bit wr, input logic [9:0] a, input logic [7:0] d,
                     input bit err, input logic [7:0] exp_rd);
    chk($sformatf("ready k%0d", k), 32'(rdy[k]), 32'd1);
    rv[k] = 1'b1;
    rw[k] = wr;
    ra[k] = a;
    rd[k] = d;
    @(posedge clk);
    #1;
    rv[k] = 1'b0;
    rw[k] = 1'($urandom);
    ra[k] = 10'($urandom);
    rd[k] = 8'($urandom);
    watch(k, wr, a, d, err, exp_rd);
    $display("txn k=%0d %s addr=%03h wdata=%02h exp_rdata=%02h err=%0d rdata=%02h",
             k, wr ? "WR" : "RD", a, d, exp_rd, err, rdata[k]);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0;
      rw[k] = 1'b0;
      ra[k] = '0;
      rd[k] = '0;
      for (int i = 0; i < 1024; i++) refm[k][i] = 8'h00;
    end

    tbl.push_back('{0, 1'b1, 10'h3FF, 8'hA5, 1'b0, 8'h00});
    tbl.push_back('{0, 1'b0, 10'h3FF, 8'h00, 1'b0, 8'hA5});
    tbl.push_back('{0, 1'b1, 10'h3FE, 8'h5C, 1'b0, 8'h00});
    tbl.push_back('{1, 1'b0, 10'd1000, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1, 1'b1, 10'd1023, 8'hEE, 1'b1, 8'h00});
    tbl.push_back('{1, 1'b1, 10'd0,   8'h5A, 1'b0, 8'h00});
    tbl.push_back('{1, 1'b1, 10'd1,   8'hC3, 1'b0, 8'h00});
    tbl.push_back('{1, 1'b1, 10'd999, 8'h7E, 1'b0, 8'h00});
    tbl.push_back('{1, 1'b0, 10'd0,   8'h00, 1'b0, 8'h5A});
    tbl.push_back('{1, 1'b0, 10'd1,   8'h00, 1'b0, 8'hC3});
    tbl.push_back('{1, 1'b0, 10'd999, 8'h00, 1'b0, 8'h7E});
    tbl.push_back('{2, 1'b1, 10'd0,    8'h0F, 1'b0, 8'h00});
    tbl.push_back('{2, 1'b1, 10'd1,    8'hF0, 1'b0, 8'h00});
    tbl.push_back('{2, 1'b1, 10'd1023, 8'h3C, 1'b0, 8'h00});
    tbl.push_back('{2, 1'b0, 10'd0,    8'h00, 1'b0, 8'h0F});
    tbl.push_back('{2, 1'b0, 10'd1,    8'h00, 1'b0, 8'hF0});
    tbl.push_back('{2, 1'b0, 10'd1023, 8'h00, 1'b0, 8'h3C});

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset k%0d", k),
          32'({rdy[k], rdn[k], wrn[k], rspv[k], wdn[k], rerr[k], ao[k], rdata[k]}),
          32'({6'b111000, 10'd0, 8'd0}));
    rst_n = 1'b1;

    // Directed table; first handshake lands on the first edge after reset release.
    foreach (tbl[i]) begin
      txn(tbl[i].k, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].err, tbl[i].exp_rd);
      if (tbl[i].wr && !tbl[i].err) refm[tbl[i].k][tbl[i].a] = tbl[i].d;
    end
    chk("rdata hold k0", 32'(rdata[0]), 32'h0A5);

    // Back-to-back writes with req_valid held; inputs change mid-transaction.
    chk("ready b2b", 32'(rdy[0]), 32'd1);
    rv[0] = 1'b1;
    rw[0] = 1'b1;
    ra[0] = 10'd0;
    rd[0] = 8'h11;
    @(posedge clk);
    #1;
    ra[0] = 10'd1;
    rd[0] = 8'h22;
    watch(0, 1'b1, 10'd0, 8'h11, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    watch(0, 1'b1, 10'd1, 8'h22, 1'b0, 8'h00);
    $display("txn k=0 WR b2b addr=000/001 wdata=11/22");
    refm[0][0] = 8'h11;
    refm[0][1] = 8'h22;
    txn(0, 1'b0, 10'd0, 8'h00, 1'b0, 8'h11);
    txn(0, 1'b0, 10'd1, 8'h00, 1'b0, 8'h22);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      int k;
      bit wr;
      bit err;
      logic [9:0] a;
      logic [7:0] d;
      k = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      if (k == 1 && $urandom_range(0, 4) == 0) a = 10'($urandom_range(1000, 1023));
      else a = 10'($urandom_range(0, size_of(k) - 1));
      err = (int'(a) >= size_of(k));
      d = 8'($urandom);
      txn(k, wr, a, d, err, refm[k][a]);
      if (wr && !err) refm[k][a] = d;
    end

    // Reset in the second strobe cycle of a write on instance 0.
    rv[0] = 1'b1;
    rw[0] = 1'b1;
    ra[0] = 10'h200;
    rd[0] = 8'h99;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset strobe", 32'(ctl(0)), 32'(6'b010000));
    rst_n = 1'b0;
    #1;
    chk("reset mid-strobe", 32'(ctl(0)), 32'(6'b111000));
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("post-reset n%0d", n), 32'(ctl(0)), 32'(6'b111000));
    end
    $display("txn k=0 WR addr=200 wdata=99 aborted by reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
